// File: rtl/mux_scan_pkg.sv
// Shared constants for the 4:1 multiplexer scan controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: FSM state encoding and the channel count.
package mux_scan_pkg;

  localparam int NCH = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

endpackage

// File: rtl/next_chan_pick.sv
// Picks the next enabled channel above cur_i, or the lowest enabled channel when first_i=1.
// Latency: combinational.
// Backpressure: none.
// Ports: mask_i channel mask, cur_i current channel, first_i ignore cur_i,
//        nxt_o picked channel (cur_i when none), last_o no qualifying channel exists.
module next_chan_pick
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0] mask_i,
  input  logic [1:0]     cur_i,
  input  logic           first_i,
  output logic [1:0]     nxt_o,
  output logic           last_o
);

  // Walk downwards so the lowest qualifying channel is the one that sticks.
  always_comb begin
    nxt_o  = cur_i;
    last_o = 1'b1;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask_i[k] && (first_i || (k > int'(cur_i)))) begin
        nxt_o  = 2'(k);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans enabled mux channels in ascending order, samples y after DWELL cycles each, emits a nibble frame.
// Latency: frame_valid rises popcount(mask)*DWELL cycles after the start edge; period popcount*DWELL+1.
// Backpressure: valid/ready; stalls in OUT with frame held and mux_y ignored until frame_ready.
// Ports: clk/rst (async high), enable, chan_en mask, mux_y sample input, s1:s0 selects,
//        frame/frame_valid/frame_ready output handshake, busy (SCAN or OUT), frame_cnt accepted frames.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [NCH-1:0] chan_en,
  input  logic           mux_y,
  output logic           s0,
  output logic           s1,
  output logic [NCH-1:0] frame,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic           busy,
  output logic [CW-1:0]  frame_cnt
);

  logic [1:0]     state_q, state_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] shadow_q, shadow_d;
  logic [NCH-1:0] frame_q, frame_d;
  logic [1:0]     sel_q, sel_d;
  logic [7:0]     dwell_q, dwell_d;
  logic           valid_q, valid_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [1:0]     first_chan, next_chan;
  logic           no_chan, next_last;
  logic           start_ok, launch, dwell_done;
  logic [NCH-1:0] shadow_wr;

  // Lowest channel of the incoming mask; no_chan doubles as the chan_en==0 test.
  next_chan_pick u_first (
    .mask_i  (chan_en),
    .cur_i   (2'd0),
    .first_i (1'b1),
    .nxt_o   (first_chan),
    .last_o  (no_chan)
  );

  next_chan_pick u_next (
    .mask_i  (mask_q),
    .cur_i   (sel_q),
    .first_i (1'b0),
    .nxt_o   (next_chan),
    .last_o  (next_last)
  );

  assign start_ok   = enable && !no_chan;
  assign dwell_done = (dwell_q == 8'(DWELL - 1));

  // A new frame starts from IDLE or directly on the OUT handshake edge.
  assign launch = start_ok &&
                  ((state_q == IDLE) || ((state_q == OUT) && valid_q && frame_ready));

  always_comb begin
    shadow_wr        = shadow_q;
    shadow_wr[sel_q] = mux_y;
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    sel_d    = sel_q;
    dwell_d  = dwell_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: ;
      SCAN: begin
        if (dwell_done) begin
          shadow_d = shadow_wr;
          dwell_d  = 8'd0;
          if (next_last) begin
            // Frame includes the bit being written on this same edge.
            state_d = OUT;
            frame_d = shadow_wr;
            valid_d = 1'b1;
          end else begin
            sel_d = next_chan;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      OUT: begin
        if (valid_q && frame_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d  = SCAN;
      mask_d   = chan_en;
      sel_d    = first_chan;
      dwell_d  = 8'd0;
      shadow_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      sel_q    <= 2'd0;
      dwell_q  <= 8'd0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      sel_q    <= sel_d;
      dwell_q  <= dwell_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s0          = sel_q[0];
  assign s1          = sel_q[1];
  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign busy        = (state_q != IDLE);
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: directed scenarios plus randomized traffic against a frame-level model.
// Latency: n/a.
// Backpressure: frame_ready driven directly by the bench.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;

  localparam int DW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [3:0]    chan_en;
  logic          mux_y;
  logic          s0, s1;
  logic [3:0]    frame;
  logic          frame_valid;
  logic          frame_ready;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic [3:0]    mux_in;

  always #5 clk = ~clk;

  // Behavioural 4:1 multiplexer fed by the controller's selects.
  assign mux_y = mux_in[{s1, s0}];

  mux_scan_ctrl #(.DWELL(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .chan_en     (chan_en),
    .mux_y       (mux_y),
    .s0          (s0),
    .s1          (s1),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level model: a frame is the ascending list of enabled channels, each owning
  // DW consecutive cycles counted from the start edge; the sample is taken at the end
  // of its slot, and the frame is presented once all slots have elapsed.
  localparam int PH_IDLE = 0;
  localparam int PH_SCAN = 1;
  localparam int PH_HOLD = 2;

  int       m_phase;
  int       m_age;
  int       m_chans[$];
  bit [3:0] m_shadow;
  bit [3:0] m_frame;
  bit       m_valid;
  int       m_cnt;
  int       m_sel;
  int       m_hs;

  function automatic void m_reset();
    m_phase  = PH_IDLE;
    m_age    = 0;
    m_chans.delete();
    m_shadow = '0;
    m_frame  = '0;
    m_valid  = 1'b0;
    m_cnt    = 0;
    m_sel    = 0;
  endfunction

  function automatic void m_begin(input logic [3:0] m);
    m_chans.delete();
    for (int k = 0; k < 4; k++) if (m[k]) m_chans.push_back(k);
    m_phase  = PH_SCAN;
    m_age    = 0;
    m_shadow = '0;
    m_sel    = m_chans[0];
  endfunction

  // Advance the model across one rising edge using the inputs currently driven.
  function automatic void m_edge();
    bit go;
    int ch;
    go = enable && (chan_en != 4'd0);
    case (m_phase)
      PH_IDLE: if (go) m_begin(chan_en);
      PH_SCAN: begin
        ch = m_chans[m_age / DW];
        if ((m_age + 1) % DW == 0) m_shadow[ch] = mux_in[ch];
        m_age++;
        if (m_age == m_chans.size() * DW) begin
          m_phase = PH_HOLD;
          m_valid = 1'b1;
          m_frame = m_shadow;
        end else begin
          m_sel = m_chans[m_age / DW];
        end
      end
      default: begin
        if (frame_ready) begin
          m_valid = 1'b0;
          m_cnt   = (m_cnt + 1) % (1 << CW);
          m_hs++;
          if (go) m_begin(chan_en);
          else    m_phase = PH_IDLE;
        end
      end
    endcase
  endfunction

  task automatic check_outputs();
    chk("sel",   32'({s1, s0}),    32'(m_sel));
    chk("valid", 32'(frame_valid), 32'(m_valid));
    chk("busy",  32'(busy),        32'(m_phase != PH_IDLE));
    chk("frame", 32'(frame),       32'(m_frame));
    chk("cnt",   32'(frame_cnt),   32'(m_cnt));
  endtask

  // Inputs are set at the falling edge; the model consumes them for the next rising edge.
  task automatic step();
    m_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_to_valid(output int n);
    n = 0;
    while (!frame_valid && n < 64) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    m_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;

    rst = 1'b1; enable = 1'b0; chan_en = 4'd0; frame_ready = 1'b0; mux_in = 4'd0;
    m_reset();
    m_hs = 0;
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Full mask, fixed inputs i3..i0 = 1,1,0,1.
    mux_in = 4'b1101; chan_en = 4'b1111; enable = 1'b1; frame_ready = 1'b1;
    step();
    chk("start_sel", 32'({s1, s0}), 32'd0);
    run_to_valid(n);
    chk("lat_1111", 32'(n), 32'd16);
    chk("frame_1101", 32'(frame), 32'b1101);
    enable = 1'b0;
    step();
    chk("cnt_first", 32'(frame_cnt), 32'd1);
    chk("idle_after_first", 32'(busy), 32'd0);

    // Sparse mask: only channels 1 and 3 visited.
    mux_in = 4'b1111; chan_en = 4'b1010; enable = 1'b1;
    step();
    chk("sparse_sel", 32'({s1, s0}), 32'd1);
    run_to_valid(n);
    chk("lat_1010", 32'(n), 32'd8);
    chk("frame_1010", 32'(frame), 32'b1010);
    enable = 1'b0;
    step();

    // Backpressure: hold ready low for 10 cycles after valid.
    chan_en = 4'b1111; enable = 1'b1; frame_ready = 1'b0;
    step();
    run_to_valid(n);
    for (int i = 0; i < 10; i++) begin
      mux_in = 4'($urandom);
      step();
      chk("bp_valid", 32'(frame_valid), 32'd1);
      chk("bp_sel", 32'({s1, s0}), 32'd3);
      chk("bp_cnt", 32'(frame_cnt), 32'd2);
    end
    frame_ready = 1'b1; chan_en = 4'b0110;
    step();
    chk("bp_release_cnt", 32'(frame_cnt), 32'd3);
    chk("bp_restart_busy", 32'(busy), 32'd1);
    chk("bp_restart_sel", 32'({s1, s0}), 32'd1);

    // Reset mid-scan, enable left high: restart on the first edge after release.
    for (int i = 0; i < 5; i++) step();
    pulse_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    step();
    chk("restart_after_rst", 32'(busy), 32'd1);

    // Mask change mid-scan is ignored for the frame in flight.
    mux_in = 4'b1111;
    step(); step();
    chan_en = 4'b1001;
    run_to_valid(n);
    chk("old_mask_bits", 32'(frame & 4'b1001), 32'd0);
    chk("old_mask_frame", 32'(frame), 32'b0110);
    enable = 1'b0;
    step();

    // Enable with an empty mask never starts.
    chan_en = 4'd0; enable = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("empty_mask_busy", 32'(busy), 32'd0);
    chk("empty_mask_valid", 32'(frame_valid), 32'd0);

    // Enable dropped mid-frame: frame still delivered, then idle.
    chan_en = 4'b1111;
    step();
    step(); step(); step();
    enable = 1'b0;
    run_to_valid(n);
    chk("drop_en_valid", 32'(frame_valid), 32'd1);
    step();
    chk("drop_en_idle", 32'(busy), 32'd0);
    step();
    chk("drop_en_still_idle", 32'(busy), 32'd0);

    // Counter wrap after 256 accepted frames.
    pulse_reset();
    m_hs = 0;
    enable = 1'b1; chan_en = 4'b0001; frame_ready = 1'b1;
    guard = 0;
    while (m_hs < 256 && guard < 4000) begin
      mux_in = 4'($urandom);
      step();
      guard++;
    end
    chk("wrap_hs", 32'(m_hs), 32'd256);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      enable      = ($urandom_range(0, 9) != 0);
      chan_en     = 4'($urandom);
      frame_ready = ($urandom_range(0, 2) != 0);
      mux_in      = 4'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential scan controller that sits directly upstream of the gate-level 4:1 multiplexer and consumes its output. It drives the select lines `s1:s0` through the enabled channels in ascending order and holds each one for a programmable dwell time. At the end of each dwell it samples the multiplexer output `y`, then packs the four sampled bits into a nibble frame and delivers it over a valid/ready handshake.

## Interface
- `DWELL`, default 4: cycles each select value is held before sampling; legal range 1..255.
- `CW`, default 8: width of the frame counter.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: request continuous scanning.
- `chan_en` in 4: per-channel enable mask, bit k = channel k.
- `mux_y` in 1: multiplexer output `y`.
- `s0`, `s1` out 1 each: multiplexer selects, channel = {s1,s0}.
- `frame` out 4: captured frame, bit k = sample of channel k.
- `frame_valid` out 1: frame available.
- `frame_ready` in 1: consumer accepts frame.
- `busy` out 1: high in SCAN or OUT.
- `frame_cnt` out CW: count of accepted frames.

## Operation
- States are IDLE, SCAN and OUT.
- **IDLE**
  - Moves to SCAN on an edge where `enable`=1 and `chan_en`≠0.
  - At that edge: latch `chan_en` into `mask_q`, set select to the lowest set bit of `mask_q`, clear `dwell_cnt` and the frame shadow.
  - If `chan_en`=0, stay in IDLE and produce no frame.
- **SCAN**
  - `dwell_cnt` increments every cycle.
  - On the edge where `dwell_cnt`=DWELL-1:
    - write `mux_y` into shadow bit [sel];
    - clear `dwell_cnt`;
    - advance the select to the next higher set bit of `mask_q`.
  - If no higher bit is set, go to OUT instead: load `frame` from the shadow (including the bit written on this edge) and set `frame_valid`=1.
  - Channels that are disabled in the mask are never selected, and their frame bits are 0.
- **OUT**
  - Select holds the last channel visited; `frame` and `frame_valid` are held stable.
  - On the edge where `frame_valid`&&`frame_ready`:
    - clear `frame_valid`;
    - increment `frame_cnt`, which wraps from 2^CW-1 to 0.
  - Next state on that edge:
    - `enable`=1 and `chan_en`≠0: go to SCAN with the IDLE-entry actions (a new mask is latched).
    - Otherwise: go to IDLE.
- **Mask and enable changes**
  - `chan_en` changes during a frame have no effect until the next frame start.
  - Deasserting `enable` mid-SCAN does not abort the scan: the frame completes and is delivered.
- **Reset**
  - Any state, including mid-scan: the state becomes IDLE immediately.
  - All outputs reset to 0: `s0`, `s1`, `frame`, `frame_valid`, `busy`, `frame_cnt`.
  - `mask_q`, `dwell_cnt` and the shadow also reset to 0.

## Timing
- The select changes only on clock edges, so the multiplexer always has at least one full cycle to settle before `mux_y` is sampled.
- Latency: `frame_valid` rises N·DWELL cycles after the IDLE→SCAN edge, where N is the popcount of the latched mask.
- Back-to-back operation with `frame_ready` held high: the next frame's select starts on the handshake edge. Frame period is N·DWELL+1 cycles.
- Backpressure:
  - There is no overrun: scanning stalls in OUT indefinitely.
  - While stalled, `mux_y` is ignored.
- The handshake edge with `enable`=0 returns the block to IDLE with `busy`=0 on the following cycle.

## Structure
- Shared package `mux_scan_pkg`:
  - state encoding localparams IDLE=2'd0, SCAN=2'd1, OUT=2'd2;
  - channel count constant NCH=4.
- One sub-module: `next_chan_pick`, a combinational function. Given the 4-bit mask and the current channel, it returns the next higher set channel and a `last` flag. The same block, given the mask alone, returns the lowest set channel.
- The FSM, dwell counter, shadow register and frame counter all live in the top module.

## Test plan
- DWELL=4, mask 4'b1111, inputs i0=1, i1=0, i2=1, i3=1, ready=1 → select sequence 0,1,2,3 for 4 cycles each; frame=4'b1101 with valid 16 cycles after start; `frame_cnt`=1.
- Mask 4'b1010 → only channels 1 and 3 visited; valid after 8 cycles; frame bits 0 and 2 = 0.
- Ready held low 10 cycles after valid → valid stays 1, frame stable, select held at 3, `frame_cnt` unchanged; ready=1 → `frame_cnt` increments and the next scan starts on the same edge.
- Assert `rst` mid-SCAN at cycle 6 → all outputs 0 immediately; with `enable` still high, a new frame starts on the first edge after release.
- 256 frames with CW=8 → `frame_cnt` wraps 255→0. Drop `enable` mid-frame → that frame is delivered, then IDLE with `busy`=0.
- `chan_en`=0 with `enable`=1 → stays IDLE, no valid. Change `chan_en` mid-scan → the current frame uses the old mask.
